ssm_token_feeder: RTL and testbench
===================================

// Module: ssm_token_feeder
// PURPOSE
//  Initiator side of the SSM core's start/done handshake (B=1 only). Collects one token's operands
//  (dt, dA, Bmat, C, D, x, h_prev) from a 16-bit word stream into the core's flat buses, pulses
//  core_start, waits for core_done, captures y_flat and returns it as a word stream. It is the
//  front/back end that turns the parallel core into a streaming token engine.
// PARAMETERS
//  H 4 heads | P 4 head dim | N 4 state dim | DW 16 word width (fp16, passed through untouched)
//  TIMEOUT 4096 max WAIT cycles before abort | LEN 3H+2N+H*P+H*P*N words/frame (localparam, 100)
// PORTS
//  clk  in 1 clock | rst  in 1 reset, synchronous, active-low
//  s_data in DW operand word | s_valid in 1 | s_ready out 1 | s_last in 1 marks final frame word
//  m_data out DW y word | m_valid out 1 | m_ready in 1 | m_last out 1 final y word
//  core_dt_flat, core_dA_flat, core_D_flat out H*DW | core_Bmat_flat, core_C_flat out N*DW
//  core_x_flat out H*P*DW | core_h_prev_flat out H*P*N*DW | core_start out 1 | core_done in 1
//  core_y_flat in H*P*DW | err_clr in 1 clears sticky errors
//  err_len out 1 sticky framing error | err_timeout out 1 sticky | busy out 1 (state!=LOAD)
//  frame_cnt out 16 completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state LOAD, word counters 0, all outputs 0, operand/y regs 0.
//  Frame order: dt[0..H-1], dA[H], Bmat[N], C[N], D[H], x[H*P], h_prev[H*P*N]; element i of a
//   field lands at flat[i*DW +: DW]; x/h index = (h*P+p) / ((h*P+p)*N+n).
//  FSM LOAD -> FIRE -> WAIT -> DRAIN -> LOAD; SKIP for resync.
//  LOAD: s_ready=1; word k written on s_valid&s_ready, k++.
//   - s_last with k<LEN-1: err_len<=1, frame dropped, k<=0, stay LOAD (no core_start).
//   - k==LEN-1 with s_last: -> FIRE. Without s_last: err_len<=1, -> SKIP.
//  SKIP: s_ready=1, words discarded until an accepted s_last, then k<=0 -> LOAD.
//  FIRE: core_start=1 for exactly one cycle, -> WAIT. Operand buses held constant FIRE..DRAIN
//   (core samples them over its whole run); s_ready=0 outside LOAD/SKIP.
//  WAIT: wait counter increments; core_done=1 -> y_reg<=core_y_flat on that edge, -> DRAIN.
//   Counter reaching TIMEOUT with no done: err_timeout<=1, -> LOAD, nothing emitted.
//   core_done in any state other than WAIT is ignored (covers late done after timeout).
//  DRAIN: m_valid=1, m_data=y_reg[j*DW +: DW], j=0..H*P-1; m_last=(j==H*P-1); j++ on handshake;
//   m_data/m_last stable while m_valid&!m_ready. Last handshake: frame_cnt++, -> LOAD, s_ready=1
//   next cycle. Latency: last s word -> core_start = 1 cycle; core_done -> first m_valid = 1 cycle.
//  err_clr=1 clears both errors; a same-cycle set wins over clear.
//  Reset mid-frame in any state discards the frame; this block does not reset the core, so the
//   integration drives core rst from the same source, inverted (core reset is active-high).
// STRUCTURE
//  Shared package ssm_pkg: DW, H/P/N defaults, field offsets (OFF_DT..OFF_H), LEN, state encoding.
//  One sub-module: ssm_y_serializer (y_reg capture + DRAIN word mux/counter/m_last).
//  Counters are $clog2-sized; the operand store is one flat reg written by word index.
// TESTING (H=P=N=4, DW=16, LEN=100, TIMEOUT=64)
//  1 stream words 0x0000..0x0063, s_last on #99 -> dt_flat[15:0]=0, dA[15:0]=0x0004,
//    h_prev[15:0]=0x0024; core_start high 1 cycle, 1 cycle after last handshake; s_ready=0.
//  2 core_done 30 cycles later, y word j=0x3C00+j, m_ready toggling -> m_data 0x3C00..0x3C0F
//    in order, held while stalled; m_last on 0x3C0F only; frame_cnt=1.
//  3 s_last on word #50 -> err_len=1, no core_start; next clean 100-word frame runs normally.
//  4 no s_last on #99, s_last on #120 -> err_len=1, words 100..120 dropped, next frame clean.
//  5 no core_done -> err_timeout=1 64 cycles after core_start, state LOAD, m_valid never 1;
//    core_done at cycle 70 ignored.
//  6 rst=0 one cycle mid-DRAIN (j=5) -> m_valid=0, frame_cnt=0, s_ready=1 once released.

Source files
------------

// File: rtl/ssm_pkg.sv
// Shared definitions for the SSM token front/back end: default geometry, frame layout and FSM states.
package ssm_pkg;

  localparam int DW_DEF = 16;
  localparam int H_DEF  = 4;
  localparam int P_DEF  = 4;
  localparam int N_DEF  = 4;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_DRAIN,
    ST_SKIP
  } state_e;

  typedef enum logic [2:0] {
    F_DT,
    F_DA,
    F_BMAT,
    F_C,
    F_D,
    F_X,
    F_H
  } field_e;

  // Word offset of each operand field inside one frame, in stream order.
  function automatic int field_off(input field_e f, input int h, input int p, input int n);
    case (f)
      F_DT:    return 0;
      F_DA:    return h;
      F_BMAT:  return 2 * h;
      F_C:     return 2 * h + n;
      F_D:     return 2 * h + 2 * n;
      F_X:     return 3 * h + 2 * n;
      default: return 3 * h + 2 * n + h * p;
    endcase
  endfunction

  function automatic int frame_len(input int h, input int p, input int n);
    return 3 * h + 2 * n + h * p + h * p * n;
  endfunction

  localparam int OFF_DT   = field_off(F_DT,   H_DEF, P_DEF, N_DEF);
  localparam int OFF_DA   = field_off(F_DA,   H_DEF, P_DEF, N_DEF);
  localparam int OFF_BMAT = field_off(F_BMAT, H_DEF, P_DEF, N_DEF);
  localparam int OFF_C    = field_off(F_C,    H_DEF, P_DEF, N_DEF);
  localparam int OFF_D    = field_off(F_D,    H_DEF, P_DEF, N_DEF);
  localparam int OFF_X    = field_off(F_X,    H_DEF, P_DEF, N_DEF);
  localparam int OFF_H    = field_off(F_H,    H_DEF, P_DEF, N_DEF);
  localparam int LEN      = frame_len(H_DEF, P_DEF, N_DEF);

endpackage

// File: rtl/ssm_y_serializer.sv
// Captures the core's y vector on done and replays it as a ready/valid word stream.
module ssm_y_serializer #(
  parameter int DW    = 16,
  parameter int WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [WORDS*DW-1:0]   y_in,
  input  logic                  active,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  drain_done
);

  localparam int JW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [WORDS*DW-1:0] y_reg;
  logic [JW-1:0]       j;

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_reg <= '0;
      j     <= '0;
    end else if (capture) begin
      y_reg <= y_in;
      j     <= '0;
    end else if (active && m_ready) begin
      // NOTE: state updates use <= so every flop samples pre-edge values; = here would chain j through y_reg reads.
      j <= m_last ? '0 : j + 1'b1;
    end
  end

  // Word and last flag come straight from registers, so they hold steady across a stall.
  assign m_valid    = active;
  assign m_data     = y_reg[int'(j)*DW +: DW];
  assign m_last     = active && (j == JW'(WORDS - 1));
  assign drain_done = m_last && m_ready;

endmodule

// File: rtl/ssm_token_feeder.sv
// Streams one token's operands into the SSM core, fires it, and streams the y result back out.
module ssm_token_feeder
  import ssm_pkg::*;
#(
  parameter int H       = H_DEF,
  parameter int P       = P_DEF,
  parameter int N       = N_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic [DW-1:0]        m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [H*DW-1:0]      core_dt_flat,
  output logic [H*DW-1:0]      core_dA_flat,
  output logic [H*DW-1:0]      core_D_flat,
  output logic [N*DW-1:0]      core_Bmat_flat,
  output logic [N*DW-1:0]      core_C_flat,
  output logic [H*P*DW-1:0]    core_x_flat,
  output logic [H*P*N*DW-1:0]  core_h_prev_flat,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [H*P*DW-1:0]    core_y_flat,
  input  logic                 err_clr,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int FLEN = frame_len(H, P, N);
  localparam int KW   = $clog2(FLEN);
  localparam int WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state, state_nxt;
  logic [KW-1:0]       k;
  logic [WW-1:0]       wcnt;
  logic [FLEN*DW-1:0]  op_store;
  logic                s_hs;
  logic                k_last;
  logic                set_len, set_to;
  logic                capture, drain_active, drain_done;

  assign s_hs   = s_valid && s_ready;
  assign k_last = (k == KW'(FLEN - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_nxt    = state;
    s_ready      = 1'b0;
    core_start   = 1'b0;
    set_len      = 1'b0;
    set_to       = 1'b0;
    capture      = 1'b0;
    drain_active = 1'b0;
    case (state)
      ST_LOAD: begin
        s_ready = rst;
        if (s_hs) begin
          if (s_last && k_last) begin
            state_nxt = ST_FIRE;
          end else if (s_last) begin
            set_len = 1'b1;
          end else if (k_last) begin
            set_len   = 1'b1;
            state_nxt = ST_SKIP;
          end
        end
      end
      ST_SKIP: begin
        s_ready = rst;
        if (s_hs && s_last) state_nxt = ST_LOAD;
      end
      ST_FIRE: begin
        core_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          capture   = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (wcnt == WW'(TIMEOUT - 1)) begin
          set_to    = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        drain_active = 1'b1;
        if (drain_done) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_LOAD;
      k           <= '0;
      wcnt        <= '0;
      // NOTE: the operand store is cleared on reset so the core never sees stale operands from a discarded frame.
      op_store    <= '0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_LOAD && s_hs) begin
        op_store[int'(k)*DW +: DW] <= s_data;
        k <= (s_last || k_last) ? '0 : k + 1'b1;
      end
      wcnt        <= (state == ST_WAIT) ? wcnt + 1'b1 : '0;
      // A set in the same cycle as a clear wins.
      err_len     <= set_len | (err_len & ~err_clr);
      err_timeout <= set_to | (err_timeout & ~err_clr);
      frame_cnt   <= frame_cnt + 16'(drain_done);
    end
  end

  // Fields sit contiguously in stream order, so each bus is a fixed slice of the store.
  assign core_dt_flat     = op_store[field_off(F_DT,   H, P, N)*DW +: H*DW];
  assign core_dA_flat     = op_store[field_off(F_DA,   H, P, N)*DW +: H*DW];
  assign core_Bmat_flat   = op_store[field_off(F_BMAT, H, P, N)*DW +: N*DW];
  assign core_C_flat      = op_store[field_off(F_C,    H, P, N)*DW +: N*DW];
  assign core_D_flat      = op_store[field_off(F_D,    H, P, N)*DW +: H*DW];
  assign core_x_flat      = op_store[field_off(F_X,    H, P, N)*DW +: H*P*DW];
  assign core_h_prev_flat = op_store[field_off(F_H,    H, P, N)*DW +: H*P*N*DW];
  assign busy             = (state != ST_LOAD);

  ssm_y_serializer #(
    .DW    (DW),
    .WORDS (H*P)
  ) u_y_ser (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .y_in       (core_y_flat),
    .active     (drain_active),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .drain_done (drain_done)
  );

endmodule

// File: tb/tb_ssm_token_feeder.sv
// Randomized bench for ssm_token_feeder against a transaction-level frame/y-stream model.
module tb_ssm_token_feeder;

  localparam int H = 4, P = 4, N = 4, DW = 16, TO = 64;
  localparam int LEN = 100, HP = H * P;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [DW-1:0]       s_data = '0;
  logic                s_valid = 1'b0, s_last = 1'b0;
  logic                s_ready;
  logic [DW-1:0]       m_data;
  logic                m_valid, m_last;
  logic                m_ready = 1'b0;
  logic [H*DW-1:0]     core_dt_flat, core_dA_flat, core_D_flat;
  logic [N*DW-1:0]     core_Bmat_flat, core_C_flat;
  logic [HP*DW-1:0]    core_x_flat;
  logic [HP*N*DW-1:0]  core_h_prev_flat;
  logic                core_start;
  logic                core_done = 1'b0;
  logic [HP*DW-1:0]    core_y_flat = '0;
  logic                err_clr = 1'b0;
  logic                err_len, err_timeout, busy;
  logic [15:0]         frame_cnt;

  ssm_token_feeder #(.H(H), .P(P), .N(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .core_dt_flat(core_dt_flat), .core_dA_flat(core_dA_flat), .core_D_flat(core_D_flat),
    .core_Bmat_flat(core_Bmat_flat), .core_C_flat(core_C_flat), .core_x_flat(core_x_flat),
    .core_h_prev_flat(core_h_prev_flat), .core_start(core_start), .core_done(core_done),
    .core_y_flat(core_y_flat), .err_clr(err_clr), .err_len(err_len),
    .err_timeout(err_timeout), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  // Model state: words of the current frame, expected y words, flags and completed-frame count.
  logic [15:0] words [LEN];
  logic [15:0] y_q [$];
  int          exp_frame_cnt = 0;
  bit          exp_err_len = 0, exp_err_to = 0;
  bit          start_allowed = 0;
  bit          mon_en = 0;
  int          m_ready_mode = 0;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (m_ready_mode)
      0:       m_ready = 1'($urandom_range(0, 1));
      1:       m_ready = 1'b1;
      default: m_ready = ~m_ready;
    endcase
  end

  // Cycle monitor: flags, frame count, core_start discipline and the y stream against the model.
  bit          prev_stall = 0;
  logic [16:0] prev_word = '0;
  always @(negedge clk) begin
    if (!mon_en || !rst) begin
      prev_stall = 0;
    end else begin
      check("err_len", err_len, exp_err_len);
      check("err_timeout", err_timeout, exp_err_to);
      check("frame_cnt", frame_cnt, 16'(exp_frame_cnt));
      if (!start_allowed) check("core_start_idle", core_start, 1'b0);
      if (prev_stall) begin
        check("m_valid_held", m_valid, 1'b1);
        check("m_word_held", {m_last, m_data}, prev_word);
      end
      if (y_q.size() == 0) begin
        check("m_valid_idle", m_valid, 1'b0);
        prev_stall = 0;
      end else if (m_valid) begin
        check("m_data", m_data, y_q[0]);
        check("m_last", m_last, y_q.size() == 1);
        prev_stall = !m_ready;
        prev_word  = {m_last, m_data};
        if (m_ready) begin
          void'(y_q.pop_front());
          if (y_q.size() == 0) exp_frame_cnt++;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic check_operands();
    logic [1023:0] e;
    e = '0; for (int i = 0; i < H; i++) e[i*16 +: 16] = words[i];
    check("dt_flat", core_dt_flat, e);
    e = '0; for (int i = 0; i < H; i++) e[i*16 +: 16] = words[4 + i];
    check("dA_flat", core_dA_flat, e);
    e = '0; for (int i = 0; i < N; i++) e[i*16 +: 16] = words[8 + i];
    check("Bmat_flat", core_Bmat_flat, e);
    e = '0; for (int i = 0; i < N; i++) e[i*16 +: 16] = words[12 + i];
    check("C_flat", core_C_flat, e);
    e = '0; for (int i = 0; i < H; i++) e[i*16 +: 16] = words[16 + i];
    check("D_flat", core_D_flat, e);
    e = '0;
    for (int h = 0; h < H; h++)
      for (int p = 0; p < P; p++) e[(h*P + p)*16 +: 16] = words[20 + h*P + p];
    check("x_flat", core_x_flat, e);
    e = '0;
    for (int h = 0; h < H; h++)
      for (int p = 0; p < P; p++)
        for (int n = 0; n < N; n++) e[((h*P + p)*N + n)*16 +: 16] = words[36 + (h*P + p)*N + n];
    check("h_prev_flat", core_h_prev_flat, e);
  endtask

  task automatic send_word(input logic [15:0] d, input bit last, input bit clr, output bit ok);
    if ($urandom_range(0, 3) == 0) tick();
    s_data = d; s_last = last; s_valid = 1'b1; err_clr = clr;
    ok = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      ok = s_ready;
      tick();
      if (ok) break;
    end
    s_valid = 1'b0; s_last = 1'b0; err_clr = 1'b0;
    if (!ok) check("s_ready_load", s_ready, 1'b1);
  endtask

  task automatic send_frame(input int n, input int last_at, input bit seq, input int clr_at);
    bit ok, last, clr;
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = seq ? 16'(i) : 16'($urandom);
      if (i < LEN) words[i] = d;
      last = (i == last_at);
      clr  = (i == clr_at);
      send_word(d, last, clr, ok);
      if (clr) begin exp_err_len = 0; exp_err_to = 0; end
      if (i < LEN - 1 && last) exp_err_len = 1;
      if (i == LEN - 1) begin
        if (last) start_allowed = 1;
        else      exp_err_len = 1;
      end
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err_len = 0; exp_err_to = 0;
  endtask

  task automatic do_reset_mid_drain();
    tick();
    rst = 1'b0; mon_en = 0; m_ready_mode = 1;
    @(negedge clk);
    check("s_ready_in_reset", s_ready, 1'b0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("m_valid_after_rst", m_valid, 1'b0);
    check("frame_cnt_after_rst", frame_cnt, 16'd0);
    check("s_ready_after_rst", s_ready, 1'b1);
    check("busy_after_rst", busy, 1'b0);
    #1;
    y_q.delete(); exp_frame_cnt = 0; exp_err_len = 0; exp_err_to = 0;
    mon_en = 1;
    tick();
  endtask

  // Called right after the final accepted word of a well-formed frame.
  task automatic run_core(input int delay, input bit seq_y, input int rst_at);
    logic [HP*DW-1:0] y;
    @(negedge clk);
    check("core_start", core_start, 1'b1);
    check("s_ready_fire", s_ready, 1'b0);
    check("busy_fire", busy, 1'b1);
    check_operands();
    tick();
    start_allowed = 0;
    if (delay <= TO) begin
      for (int d = 2; d <= delay; d++) tick();
      for (int j = 0; j < HP; j++) begin
        y[j*16 +: 16] = seq_y ? 16'h3C00 + 16'(j) : 16'($urandom);
        y_q.push_back(y[j*16 +: 16]);
      end
      core_y_flat = y; core_done = 1'b1;
      @(negedge clk);
      check("m_valid_before_y", m_valid, 1'b0);
      tick();
      core_done = 1'b0; core_y_flat = {8{$urandom}};
      @(negedge clk);
      check("m_valid_latency", m_valid, 1'b1);
      if (seq_y) check("y_first_literal", m_data, 16'h3C00);
      check_operands();
      #1;
      for (int t = 0; t < 400 && y_q.size() > 0; t++) begin
        if (rst_at >= 0 && y_q.size() == HP - rst_at) begin
          do_reset_mid_drain();
          return;
        end
        @(negedge clk);
        #1;
      end
      if (y_q.size() != 0) check("drain_bound", m_valid, 1'b0);
      @(negedge clk);
      check("busy_after_drain", busy, 1'b0);
      check("s_ready_after_drain", s_ready, 1'b1);
      tick();
    end else begin
      for (int d = 2; d <= TO; d++) tick();
      tick();
      exp_err_to = 1;
      @(negedge clk);
      check("busy_after_timeout", busy, 1'b0);
      check("s_ready_after_timeout", s_ready, 1'b1);
      for (int d = TO + 2; d <= delay; d++) tick();
      core_done = 1'b1; core_y_flat = {8{$urandom}};
      tick();
      core_done = 1'b0;
      repeat (3) tick();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, delay, la;
    repeat (3) tick();
    @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_errs", {err_len, err_timeout}, 2'b00);
    check("rst_h_prev", core_h_prev_flat, '0);
    check("rst_s_ready", s_ready, 1'b0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("s_ready_released", s_ready, 1'b1);
    mon_en = 1;
    tick();

    // Sequential-word frame, core answers after 30 cycles with 0x3C00+j, m_ready toggling.
    m_ready_mode = 2;
    send_frame(LEN, LEN - 1, 1, -1);
    run_core(30, 1, -1);
    check("dt0_literal", core_dt_flat[15:0], 16'h0000);
    check("dA0_literal", core_dA_flat[15:0], 16'h0004);
    check("h_prev0_literal", core_h_prev_flat[15:0], 16'h0024);
    check("frame_cnt_literal", frame_cnt, 16'd1);

    // Early s_last drops the frame; the next clean frame runs.
    m_ready_mode = 0;
    send_frame(51, 50, 0, -1);
    repeat (3) tick();
    check("err_len_early_literal", err_len, 1'b1);
    send_frame(LEN, LEN - 1, 0, -1);
    run_core(1, 0, -1);
    pulse_clr();

    // Missing s_last: resync on word 120; clear requested on the setting word still leaves err_len set.
    send_frame(121, 120, 0, 99);
    check("err_len_skip_literal", err_len, 1'b1);
    send_frame(LEN, LEN - 1, 0, -1);
    run_core(TO, 0, -1);

    // No done within the limit; late done at 70 is ignored.
    send_frame(LEN, LEN - 1, 0, -1);
    run_core(70, 0, -1);
    check("err_timeout_literal", err_timeout, 1'b1);
    pulse_clr();

    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 5);
      m_ready_mode = $urandom_range(0, 2);
      case (kind)
        3: begin
          la = $urandom_range(0, LEN - 2);
          send_frame(la + 1, la, 0, ($urandom_range(0, 1) == 1) ? la : -1);
        end
        4: begin
          la = LEN + $urandom_range(0, 10);
          send_frame(la + 1, la, 0, -1);
        end
        5: begin
          send_frame(LEN, LEN - 1, 0, -1);
          run_core(TO + $urandom_range(2, 8), 0, -1);
        end
        default: begin
          delay = $urandom_range(1, TO);
          send_frame(LEN, LEN - 1, 0, ($urandom_range(0, 3) == 0) ? 10 : -1);
          run_core(delay, 0, -1);
        end
      endcase
      if ($urandom_range(0, 2) == 0) pulse_clr();
    end

    // Reset in the middle of draining word 5, then a clean frame afterwards.
    m_ready_mode = 1;
    send_frame(LEN, LEN - 1, 0, -1);
    run_core(10, 0, 5);
    m_ready_mode = 0;
    send_frame(LEN, LEN - 1, 0, -1);
    run_core(20, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
